// File: rtl/tcm_boot_loader_pkg.sv
// tcm_boot_loader shared types and constants.
// State encoding, tag width and mem_d tie-off values.
package tcm_boot_pkg;

    localparam int TAG_W = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic MEM_RD_TIE         = 1'b0;
    localparam logic MEM_CACHEABLE_TIE  = 1'b0;
    localparam logic MEM_INVALIDATE_TIE = 1'b0;
    localparam logic MEM_WRITEBACK_TIE  = 1'b0;
    localparam logic MEM_FLUSH_TIE      = 1'b0;

    function automatic logic [3:0] lane_bit(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/tcm_boot_loader_if.sv
// mem_d data-port bundle between the loader (master) and tcm_mem (slave).
// Signal names follow the core's mem_d port naming.
interface tcm_boot_loader_if;
    import tcm_boot_pkg::*;

    logic [31:0]      mem_d_addr_o;
    logic [31:0]      mem_d_data_wr_o;
    logic [3:0]       mem_d_wr_o;
    logic             mem_d_rd_o;
    logic             mem_d_cacheable_o;
    logic             mem_d_invalidate_o;
    logic             mem_d_writeback_o;
    logic             mem_d_flush_o;
    logic [TAG_W-1:0] mem_d_req_tag_o;
    logic             mem_d_accept_i;
    logic             mem_d_ack_i;
    logic             mem_d_error_i;
    logic [TAG_W-1:0] mem_d_resp_tag_i;
    logic [31:0]      mem_d_data_rd_i;

    modport master (
        output mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_rd_o,
        output mem_d_cacheable_o, mem_d_invalidate_o,
        output mem_d_writeback_o, mem_d_flush_o, mem_d_req_tag_o,
        input  mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
        input  mem_d_resp_tag_i, mem_d_data_rd_i
    );

    modport slave (
        input  mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_rd_o,
        input  mem_d_cacheable_o, mem_d_invalidate_o,
        input  mem_d_writeback_o, mem_d_flush_o, mem_d_req_tag_o,
        output mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
        output mem_d_resp_tag_i, mem_d_data_rd_i
    );

endinterface

// File: rtl/tcm_boot_loader_ack_tracker.sv
// Outstanding-write counter with in-order ack tag check.
// Flags error on tag mismatch, error ack, or ack with nothing outstanding.
module tcm_boot_ack_tracker
    import tcm_boot_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             accept_i,
    input  logic             ack_i,
    input  logic             error_i,
    input  logic [TAG_W-1:0] resp_tag_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             err_o
);

    localparam int CW = $clog2(MAX) + 1;

    logic [CW-1:0]    cnt_q;
    logic [TAG_W-1:0] exp_q;
    logic             err_q;
    logic             bad;
    logic             ret;

    // Classify the incoming ack against the expected tag and count.
    always_comb begin
        ret = ack_i && (cnt_q != '0);
        bad = ack_i && ((cnt_q == '0) ||
                        (resp_tag_i != exp_q) ||
                        error_i);
    end

    // Count in-flight writes, walk the expected tag, latch errors.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            exp_q <= '0;
            err_q <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            unique case ({accept_i, ret})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (ack_i) exp_q <= exp_q + 1'b1;
            if (bad)   err_q <= 1'b1;
        end
    end

    assign full_o  = (cnt_q == CW'(MAX));
    assign empty_o = (cnt_q == '0);
    assign err_o   = err_q;

endmodule

// File: rtl/tcm_boot_loader.sv
// Byte-stream image loader driving tcm_mem over mem_d.
// Packs bytes little-endian, issues tagged writes, holds the core in reset.
module tcm_boot_loader
    import tcm_boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [17:0]        len_i,
    input  logic               in_valid_i,
    input  logic [7:0]         in_data_i,
    output logic               in_ready_o,
    tcm_boot_loader_if.master  mem_d,
    output logic               core_rst_o,
    output logic               done_o,
    output logic               error_o
);

    state_e           state_q;
    logic [17:0]      len_q;
    logic [17:0]      byte_cnt_q;
    logic [15:0]      word_idx_q;
    logic [31:0]      data_q;
    logic [3:0]       strb_q;
    logic             in_ready_q;
    logic [3:0]       wr_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [TAG_W-1:0] tag_q;
    logic             core_rst_q;
    logic             done_q;
    logic             error_q;

    logic [1:0]       lane;
    logic [17:0]      byte_cnt_d;
    logic [31:0]      data_d;
    logic [3:0]       strb_d;
    logic             word_end;
    logic             take;
    logic             acc;
    logic             more;
    logic             idle_like;
    logic             trk_clr;
    logic             trk_full;
    logic             trk_empty;
    logic             trk_err;
    logic [31:0]      req_addr;
    logic             unused_rd;

    // Next packing state if the current byte handshake completes.
    always_comb begin
        lane       = byte_cnt_q[1:0];
        byte_cnt_d = byte_cnt_q + 18'd1;
        data_d     = data_q;
        data_d[{lane, 3'b000} +: 8] = in_data_i;
        strb_d     = strb_q | lane_bit(lane);
        word_end   = (lane == 2'd3) || (byte_cnt_d == len_q);
    end

    assign take      = in_valid_i & in_ready_q;
    assign acc       = (wr_q != 4'd0) & mem_d.mem_d_accept_i;
    assign more      = (byte_cnt_q != len_q);
    assign req_addr  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
    assign idle_like = (state_q == S_IDLE) ||
                       (state_q == S_DONE) ||
                       (state_q == S_ERR);
    assign trk_clr   = idle_like & start_i;
    assign unused_rd = ^mem_d.mem_d_data_rd_i;

    tcm_boot_ack_tracker #(
        .MAX (MAX_OUTSTANDING)
    ) u_trk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (trk_clr),
        .accept_i   (acc),
        .ack_i      (mem_d.mem_d_ack_i),
        .error_i    (mem_d.mem_d_error_i),
        .resp_tag_i (mem_d.mem_d_resp_tag_i),
        .full_o     (trk_full),
        .empty_o    (trk_empty),
        .err_o      (trk_err)
    );

    // Load sequencer: fill a word, issue it, drain acks, report status.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            in_ready_q <= 1'b0;
            wr_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tag_q      <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        len_q      <= len_i;
                        byte_cnt_q <= '0;
                        word_idx_q <= '0;
                        data_q     <= '0;
                        strb_q     <= '0;
                        error_q    <= 1'b0;
                        if (len_i == 18'd0) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q    <= S_FILL;
                            in_ready_q <= 1'b1;
                            done_q     <= 1'b0;
                            core_rst_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (trk_err) begin
                        in_ready_q <= 1'b0;
                        state_q    <= S_DRAIN;
                    end else if (take) begin
                        byte_cnt_q <= byte_cnt_d;
                        data_q     <= data_d;
                        strb_q     <= strb_d;
                        if (word_end) begin
                            in_ready_q <= 1'b0;
                            state_q    <= S_ISSUE;
                            if (!trk_full) begin
                                wr_q    <= strb_d;
                                addr_q  <= req_addr;
                                wdata_q <= data_d;
                                tag_q   <= word_idx_q[TAG_W-1:0];
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (wr_q != 4'd0) begin
                        if (acc) begin
                            wr_q       <= '0;
                            strb_q     <= '0;
                            data_q     <= '0;
                            word_idx_q <= word_idx_q + 16'd1;
                            if (more && !trk_err) begin
                                state_q    <= S_FILL;
                                in_ready_q <= 1'b1;
                            end else begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end else if (trk_err) begin
                        state_q <= S_DRAIN;
                    end else if (!trk_full) begin
                        wr_q    <= strb_q;
                        addr_q  <= req_addr;
                        wdata_q <= data_q;
                        tag_q   <= word_idx_q[TAG_W-1:0];
                    end
                end
                S_DRAIN: begin
                    if (trk_empty) begin
                        if (trk_err) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o               = in_ready_q;
    assign core_rst_o               = core_rst_q;
    assign done_o                   = done_q;
    assign error_o                  = error_q;
    assign mem_d.mem_d_addr_o       = addr_q;
    assign mem_d.mem_d_data_wr_o    = wdata_q;
    assign mem_d.mem_d_wr_o         = wr_q;
    assign mem_d.mem_d_req_tag_o    = tag_q;
    assign mem_d.mem_d_rd_o         = MEM_RD_TIE;
    assign mem_d.mem_d_cacheable_o  = MEM_CACHEABLE_TIE;
    assign mem_d.mem_d_invalidate_o = MEM_INVALIDATE_TIE;
    assign mem_d.mem_d_writeback_o  = MEM_WRITEBACK_TIE;
    assign mem_d.mem_d_flush_o      = MEM_FLUSH_TIE;

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Directed bench for tcm_boot_loader with a tcm_mem responder model.
// Checks packing, tags, backpressure, errors, tag wrap and async reset.
module tb_tcm_boot_loader;

    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        int unsigned cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wr;
        logic [10:0] tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [17:0] len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        core_rst;
    logic        done;
    logic        error;

    logic        hold_ack;
    logic        accept_en;
    int          err_at;

    int          ntests = 0;
    int          nfail  = 0;

    int unsigned cyc = 0;
    int          ack_total = 0;
    int unsigned err_stamp = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    int          viol = 0;
    ent_t        wlog[$];
    logic [10:0] pend[$];
    logic [31:0] mem[logic [31:0]];

    tcm_boot_loader_if bus();

    tcm_boot_loader #(
        .BASE_ADDR       (BASE),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .len_i      (len),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .mem_d      (bus.master),
        .core_rst_o (core_rst),
        .done_o     (done),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    assign bus.mem_d_accept_i  = accept_en && (bus.mem_d_wr_o != 4'd0);
    assign bus.mem_d_data_rd_i = 32'h0;

    // Cycle stamp for accept/ack timing.
    always @(posedge clk) cyc <= cyc + 1;

    // tcm_mem model: accepts, stores with strobes, acks in order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_d_ack_i      <= 1'b0;
            bus.mem_d_error_i    <= 1'b0;
            bus.mem_d_resp_tag_i <= '0;
            pend.delete();
            out_cnt = 0;
        end else begin
            if (bus.mem_d_wr_o != 4'd0 && out_cnt == 4) viol++;
            if (bus.mem_d_accept_i) out_cnt++;
            if (bus.mem_d_ack_i && out_cnt > 0) out_cnt--;
            if (out_cnt > max_out) max_out = out_cnt;
            if (bus.mem_d_accept_i) begin
                logic [31:0] v;
                ent_t e;
                e.cyc  = cyc;
                e.addr = bus.mem_d_addr_o;
                e.data = bus.mem_d_data_wr_o;
                e.wr   = bus.mem_d_wr_o;
                e.tag  = bus.mem_d_req_tag_o;
                wlog.push_back(e);
                pend.push_back(bus.mem_d_req_tag_o);
                v = mem.exists(e.addr) ? mem[e.addr] : 32'h0;
                for (int l = 0; l < 4; l++)
                    if (e.wr[l]) v[8*l +: 8] = e.data[8*l +: 8];
                mem[e.addr] = v;
            end
            if (!hold_ack && pend.size() > 0) begin
                bus.mem_d_resp_tag_i <= pend.pop_front();
                bus.mem_d_ack_i      <= 1'b1;
                ack_total++;
                bus.mem_d_error_i    <= (ack_total == err_at);
                if (ack_total == err_at) err_stamp = cyc;
            end else begin
                bus.mem_d_ack_i   <= 1'b0;
                bus.mem_d_error_i <= 1'b0;
            end
        end
    end

    function automatic logic [7:0] pat(input int seed, input int i);
        return 8'(seed + i + 1);
    endfunction

    function automatic logic [31:0] exp_word(input int seed, input int n,
                                             input int w);
        logic [31:0] v = 32'h0;
        for (int l = 0; l < 4; l++)
            if (4*w + l < n) v[8*l +: 8] = pat(seed, 4*w + l);
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input int n, input int w);
        logic [3:0] s = 4'h0;
        for (int l = 0; l < 4; l++)
            if (4*w + l < n) s[l] = 1'b1;
        return s;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs,
                       input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    task automatic do_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = 18'(l);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_bytes(input int seed, input int n, input int from,
                              input int budget, output int sent);
        int idx = from;
        int g = 0;
        while (idx < n && g < budget) begin
            @(negedge clk);
            g++;
            in_valid = 1'b1;
            in_data  = pat(seed, idx);
            if (in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        sent = idx;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!done && !error && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("end_timeout", 1'(done | error), 1'b1);
    endtask

    task automatic check_image(input string nm, input int seed,
                               input int n, input int base);
        int nw = (n + 3) / 4;
        chk({nm, "_nwords"}, wlog.size() - base, nw);
        for (int w = 0; w < nw && base + w < wlog.size(); w++) begin
            ent_t e = wlog[base + w];
            logic [31:0] a = BASE + 32'(4*w);
            logic [31:0] m = {{8{exp_strb(n, w)[3]}}, {8{exp_strb(n, w)[2]}},
                              {8{exp_strb(n, w)[1]}}, {8{exp_strb(n, w)[0]}}};
            logic [31:0] rb = mem.exists(a) ? mem[a] : 32'hxxxx_xxxx;
            chk($sformatf("%s_w%0d", nm, w),
                {e.addr, e.data, e.wr, e.tag},
                {a, exp_word(seed, n, w), exp_strb(n, w), 11'(w)});
            chk($sformatf("%s_rb%0d", nm, w), rb & m, exp_word(seed, n, w));
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_rdy"}, in_ready, 1'b0);
        chk({nm, "_wr"}, bus.mem_d_wr_o, 4'h0);
        chk({nm, "_addr"}, bus.mem_d_addr_o, 32'h0);
        chk({nm, "_data"}, bus.mem_d_data_wr_o, 32'h0);
        chk({nm, "_tag"}, bus.mem_d_req_tag_o, 11'h0);
        chk({nm, "_stat"}, {core_rst, done, error}, 3'b100);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int base;
        int late;
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        hold_ack  = 1'b0;
        accept_en = 1'b1;
        err_at    = 0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        chk("tieoff", {bus.mem_d_rd_o, bus.mem_d_cacheable_o,
                       bus.mem_d_invalidate_o, bus.mem_d_writeback_o,
                       bus.mem_d_flush_o}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        base = wlog.size();
        do_start(0);
        @(negedge clk);
        chk("len0_stat", {core_rst, done, error}, 3'b010);
        repeat (5) @(negedge clk);
        chk("len0_traffic", wlog.size() - base, 0);

        base = wlog.size();
        do_start(8);
        send_bytes(0, 8, 0, 1000, sent);
        wait_end(200);
        chk("len8_stat", {core_rst, done, error}, 3'b010);
        check_image("len8", 0, 8, base);
        chk("len8_cadence", wlog[base+1].cyc - wlog[base].cyc, 5);

        base = wlog.size();
        do_start(6);
        send_bytes(0, 6, 0, 1000, sent);
        wait_end(200);
        chk("len6_stat", {core_rst, done, error}, 3'b010);
        check_image("len6", 0, 6, base);

        base = wlog.size();
        hold_ack = 1'b1;
        do_start(40);
        send_bytes(8'h10, 40, 0, 60, sent);
        chk("hold_accepted", wlog.size() - base, 4);
        chk("hold_wr_low", bus.mem_d_wr_o, 4'h0);
        chk("hold_rst", core_rst, 1'b1);
        hold_ack = 1'b0;
        send_bytes(8'h10, 40, sent, 2000, sent);
        wait_end(200);
        chk("hold_stat", {core_rst, done, error}, 3'b010);
        check_image("hold", 8'h10, 40, base);
        chk("hold_maxout", max_out, 4);
        chk("hold_viol", viol, 0);

        base = wlog.size();
        err_at = ack_total + 3;
        do_start(32);
        send_bytes(8'h20, 32, 0, 300, sent);
        wait_end(300);
        chk("err_stat", {core_rst, done, error}, 3'b101);
        chk("err_short", 1'(sent < 32), 1'b1);
        late = 0;
        for (int i = base; i < wlog.size(); i++)
            if (wlog[i].cyc > err_stamp + 2) late++;
        chk("err_late_wr", late, 0);
        err_at = 0;

        base = wlog.size();
        do_start(8);
        send_bytes(8'h40, 8, 0, 1000, sent);
        wait_end(200);
        chk("recov_stat", {core_rst, done, error}, 3'b010);
        check_image("recov", 8'h40, 8, base);

        base = wlog.size();
        do_start(8200);
        send_bytes(8'h55, 8200, 0, 20000, sent);
        wait_end(200);
        chk("wrap_stat", {core_rst, done, error}, 3'b010);
        chk("wrap_tag7ff", wlog[base+2047].tag, 11'h7FF);
        chk("wrap_tag000", wlog[base+2048].tag, 11'h000);
        check_image("wrap", 8'h55, 8200, base);

        accept_en = 1'b0;
        do_start(4);
        send_bytes(8'h70, 4, 0, 50, sent);
        @(negedge clk);
        chk("held_req", {bus.mem_d_wr_o, core_rst}, 5'b11111);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async");
        @(negedge clk);
        rst_n = 1'b1;
        accept_en = 1'b1;
        @(negedge clk);
        base = wlog.size();
        do_start(8);
        send_bytes(8'h80, 8, 0, 1000, sent);
        wait_end(200);
        chk("restart_stat", {core_rst, done, error}, 3'b010);
        check_image("restart", 8'h80, 8, base);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/tcm_boot_loader.md
# tcm_boot_loader

Bus-master image loader that drives the core's data-port memory protocol (mem_d_*) as an initiator toward tcm_mem, replacing the simulation-only backdoor load. It accepts a byte stream, packs the bytes little-endian into 32-bit words, and issues tagged writes with in-order ack tracking. It holds the CPU in reset until the image is fully acknowledged. It sits between a host/UART byte source and the TCM data port, ahead of the core's own data master in the mux.

## Interface
- BASE_ADDR, 32'h8000_0000, TCM address of byte 0 (word aligned)
- MAX_OUTSTANDING, 4, max accepted-but-unacked writes (power of 2, ≤16)
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset asynchronous, active-low
- start_i  in  1  one-cycle pulse, sampled only in IDLE
- len_i  in  18  image length in bytes, sampled with start_i (0..131072)
- in_valid_i / in_data_i / in_ready_o  in/in/out  1/8/1  byte stream, transfer when valid&ready
- mem_d_addr_o, mem_d_data_wr_o  out  32 each  word address / write data
- mem_d_wr_o  out  4  byte strobes; mem_d_rd_o out 1, tied 0
- mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o  out  1  all tied 0
- mem_d_req_tag_o  out  11  request tag
- mem_d_accept_i, mem_d_ack_i, mem_d_error_i  in  1  responder handshakes
- mem_d_resp_tag_i  in  11  ack tag; mem_d_data_rd_i in 32, ignored
- core_rst_o  out  1  active-high reset to riscv_core
- done_o, error_o  out  1  sticky status, cleared by next start_i

## Operation
- States: IDLE, FILL, ISSUE, DRAIN, DONE, ERR.
- IDLE: in_ready_o=0. start_i with len_i=0 → DONE; otherwise latch len, clear byte count, word index, outstanding, status → FILL.
- FILL: in_ready_o=1. Each byte goes to lane byte_cnt[1:0]; strobe bit set. Word complete when lane 3 is written or the final byte (byte_cnt+1==len) is taken → ISSUE.
- ISSUE: in_ready_o=0. mem_d_wr_o=strobe mask (partial mask only on the last word, e.g. 4'b0011 for 2 remaining bytes). addr=BASE_ADDR+4*word_idx. tag=word_idx[10:0]. data=packed word, with unwritten lanes 0.
  - Request is not driven while outstanding==MAX_OUTSTANDING.
  - Once driven, addr/data/wr/tag hold stable until mem_d_accept_i.
  - On accept: outstanding+1, word_idx+1, strobes cleared. Next state is FILL if bytes remain, else DRAIN.
- Outstanding counter: accept and ack in the same cycle leave it unchanged. An ack with outstanding==0 is a protocol error.
- Ack checking is in order: the expected tag counter increments per ack. resp_tag≠expected or mem_d_error_i with ack → error flag set.
- DRAIN: wait for outstanding==0, then go to DONE, or to ERR if the error flag is set. An error seen in FILL/ISSUE stops issuing new words, finishes any held request through accept, then drains.
- DONE: done_o=1, core_rst_o=0. Stays until start_i, which reasserts core_rst_o and begins a new load.
- ERR: error_o=1, core_rst_o stays 1. Leaves only on start_i.
- Width rules: byte_cnt is 18 bits. word_idx is 16 bits; the tag wraps modulo 2048, so the in-order check compares 11 bits.

## Timing
- Reset values: in_ready_o=0, mem_d_wr_o=0, addr/data/tag=0, core_rst_o=1, done_o=0, error_o=0, state IDLE.
- All outputs are registered. mem_d_wr_o rises the cycle after the completing byte handshake.
- A zero-wait responder gives the minimum cost per full word: 4 byte cycles + 1 issue cycle.
- done_o and core_rst_o deassertion occur in the cycle after the final ack is registered.
- Asynchronous reset mid-load aborts immediately. No write is driven after reset asserts, and the core stays in reset.

## Structure
- Package tcm_boot_pkg holds the state enum, TAG_W=11, and the constant tie-off values for the unused mem_d controls.
- One natural sub-module: tcm_boot_ack_tracker. It contains the outstanding counter, the expected-tag counter and the error detect, and outputs full/empty/err.
- Packing and the FSM live in the top module.

## Test plan
- len=8, bytes 01..08, zero-wait tcm_mem → writes 0x04030201@0x80000000 (tags 0,1), then 0x08070605@0x80000004; done_o=1; core_rst_o falls after the 2nd ack; memory readback matches.
- len=6 → second write has wr=4'b0011 and data 0x00000605; done_o=1.
- Responder withholds ack for 10 cycles, len=40 → at most 4 requests accepted; mem_d_wr_o stays low while full; all 10 words land in order.
- Inject mem_d_error_i on the 3rd ack, len=32 → no new writes after error detect; error_o=1 after drain; core_rst_o stays 1; the next start_i recovers.
- start_i with len=0 → done_o next cycle with no mem_d traffic. Full load with len=131072 → tag wraps from 0x7FF to 0x000 without error.
- Assert rst_ni with a request held and accept low → all outputs are at reset values in the same cycle, and a restart then completes normally.
